freq_meter: RTL

Gated-window frequency meter on the 100 MHz system clock. Counts rising edges of an asynchronous input over a fixed gate window, publishes the count as a binary result, and converts it to 8-digit packed BCD for the seven-segment display path. It is the measuring counterpart to the clock divider: it takes a slow or external clock in and turns it back into a number.

---
 rtl/freq_meter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts rising edges of an asynchronous input
// over GATE_CYCLES clocks, publishes the binary count, then converts it to
// 8-digit packed BCD with a serial double-dabble converter.
module freq_meter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic [31:0]      freq_bcd,
    output logic             valid,
    output logic             overflow
);
    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam int STEP_W = $clog2(CNT_W + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CNT_W - 1);
    localparam logic [63:0] BCD_MAX = 64'd99_999_999;
    localparam logic [31:0] BCD_OVF = 32'h9999_9999;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    // Saturating increment: the edge counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [31:0] bcd_adjust(input logic [31:0] d);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < 8; i++) begin
            if (d[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    logic              sig_p0, sig_p1, sig_p2;
    logic              edge_det;
    logic [GATE_W-1:0] gate_cnt;
    logic              window_end;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    state_t            state, state_nxt;
    logic              conv_load, conv_shift, conv_done;
    logic [STEP_W-1:0] step_cnt;
    logic [CNT_W-1:0]  bin_sh;
    logic [31:0]       bcd_sh;
    logic [31:0]       bcd_adj;

    // Input synchronizer (p0, p1) followed by the previous-value register (p2).
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            sig_p0 <= 1'b0;
            sig_p1 <= 1'b0;
            sig_p2 <= 1'b0;
        end else begin
            sig_p0 <= sig_in;
            sig_p1 <= sig_p0;
            sig_p2 <= sig_p1;
        end
    end

    // Stage boundary: synchronized level vs. its previous value gives the rising edge.
    assign edge_det   = sig_p1 & ~sig_p2;
    assign window_end = (gate_cnt == GATE_LAST);
    assign cnt_nxt    = sat_inc(edge_cnt, edge_det);

    // Free-running gate counter; windows follow each other with no dead cycles.
    always_ff @(posedge clk_100MHz) begin
        if (rst)
            gate_cnt <= '0;
        else if (window_end)
            gate_cnt <= '0;
        else
            gate_cnt <= gate_cnt + GATE_W'(1);
    end

    // Edge counter and window-end latch; an edge in the last gate cycle still belongs to this window.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            edge_cnt <= '0;
            freq     <= '0;
            overflow <= 1'b0;
        end else if (window_end) begin
            edge_cnt <= '0;
            freq     <= cnt_nxt;
            overflow <= (64'(cnt_nxt) > BCD_MAX) || (cnt_nxt == {CNT_W{1'b1}});
        end else begin
            edge_cnt <= cnt_nxt;
        end
    end

    // Converter state register.
    always_ff @(posedge clk_100MHz) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Converter next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (window_end) state_nxt = S_CONV;
            S_CONV: if (step_cnt == STEP_LAST) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Converter control strobes.
    always_comb begin
        conv_load  = (state == S_IDLE) && window_end;
        conv_shift = (state == S_CONV);
        conv_done  = (state == S_DONE);
    end

    // Conversion step counter, restarted on every load.
    always_ff @(posedge clk_100MHz) begin
        if (rst)
            step_cnt <= '0;
        else if (conv_load)
            step_cnt <= '0;
        else if (conv_shift)
            step_cnt <= step_cnt + STEP_W'(1);
    end

    assign bcd_adj = bcd_adjust(bcd_sh);

    // Double-dabble shift registers; always loaded before use, so no reset needed.
    always_ff @(posedge clk_100MHz) begin
        if (conv_load) begin
            bin_sh <= cnt_nxt;
            bcd_sh <= '0;
        end else if (conv_shift) begin
            bin_sh <= bin_sh << 1;
            bcd_sh <= {bcd_adj[30:0], bin_sh[CNT_W-1]};
        end
    end

    // Publish the BCD result and its one-cycle strobe; overflowed windows show all nines.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            freq_bcd <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= conv_done;
            if (conv_done)
                freq_bcd <= overflow ? BCD_OVF : bcd_sh;
        end
    end
endmodule
